// File: rtl/vending_buyer_agent.sv
// rtl/vending_buyer_agent.sv - buyer agent: takes a host order, requests, pays greedily, collects result
// Optional order timeout: define VENDING_BUYER_TIMEOUT_EN.
module vending_buyer_agent #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       order_valid_i,
    input  logic [1:0] order_drink_i,
    input  logic [4:0] order_tender_i,
    output logic       order_ready_o,
    input  logic       vm_ready_i,
    input  logic       vm_start_pay_i,
    input  logic       vm_request_served_i,
    input  logic [1:0] vm_drink_i,
    input  logic [4:0] vm_changes_i,
    output logic       request_o,
    output logic [1:0] drink_select_o,
    output logic       payment_ones_o,
    output logic       payment_fives_o,
    output logic       payment_tens_o,
    output logic       done_o,
    output logic [1:0] done_drink_o,
    output logic [4:0] done_change_o,
    output logic       timeout_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQUEST    = 3'd1,
        PAY        = 3'd2,
        WAIT_SERVE = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] remaining_q;
    logic [1:0] drink_q;
    logic [4:0] change_q;
    logic [1:0] done_drink_q;
    logic [4:0] done_change_q;
    logic [4:0] coin_val;
    logic       accept;
    logic       active;
    logic       cnt_hit;

    assign accept = (state_q == IDLE) && order_valid_i;
    assign active = (state_q == REQUEST) || (state_q == PAY) || (state_q == WAIT_SERVE);

`ifdef VENDING_BUYER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout_q;

    assign cnt_hit   = active && ((cnt_q + CW'(1)) == CW'(TIMEOUT_CYCLES));
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (active) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_hit) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign cnt_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (order_valid_i) state_d = REQUEST;
            REQUEST:    if (vm_ready_i) state_d = PAY;
            // Leave PAY on the edge that spends the last unit, or at once for a zero tender
            PAY:        if (remaining_q == 5'd0 || (coin_val != 5'd0 && remaining_q == coin_val))
                            state_d = WAIT_SERVE;
            WAIT_SERVE: if (vm_request_served_i) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (cnt_hit) state_d = DONE;
    end

    always_comb begin
        coin_val        = 5'd0;
        payment_tens_o  = 1'b0;
        payment_fives_o = 1'b0;
        payment_ones_o  = 1'b0;
        if (state_q == PAY && vm_start_pay_i && remaining_q != 5'd0) begin
            if (remaining_q >= 5'd10) begin
                payment_tens_o = 1'b1;
                coin_val       = 5'd10;
            end else if (remaining_q >= 5'd5) begin
                payment_fives_o = 1'b1;
                coin_val        = 5'd5;
            end else begin
                payment_ones_o = 1'b1;
                coin_val       = 5'd1;
            end
        end
        order_ready_o  = (state_q == IDLE);
        request_o      = (state_q == REQUEST) && vm_ready_i;
        done_o         = (state_q == DONE);
        drink_select_o = drink_q;
        done_drink_o   = done_drink_q;
        done_change_o  = done_change_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            remaining_q   <= 5'd0;
            drink_q       <= 2'd0;
            change_q      <= 5'd0;
            done_drink_q  <= 2'd0;
            done_change_q <= 5'd0;
        end else begin
            if (accept) begin
                drink_q       <= order_drink_i;
                remaining_q   <= order_tender_i;
                change_q      <= 5'd0;
                done_drink_q  <= 2'd0;
                done_change_q <= 5'd0;
            end
            if ((state_q == PAY || state_q == WAIT_SERVE) && vm_changes_i != 5'd0)
                change_q <= vm_changes_i;
            if (state_q == PAY)
                remaining_q <= remaining_q - coin_val;
            if (state_q == WAIT_SERVE && vm_request_served_i) begin
                done_drink_q  <= vm_drink_i;
                done_change_q <= (vm_changes_i != 5'd0) ? vm_changes_i : change_q;
            end
            // A timeout reports no drink and no change, overriding a same-cycle serve
            if (cnt_hit) begin
                done_drink_q  <= 2'd0;
                done_change_q <= 5'd0;
            end
        end
    end

endmodule
